// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 message packer: FSM encoding, block geometry and padding helpers.
package sha256_pkg;

    localparam int DATA_WIDTH    = 32;  // word width toward the core; only 32 is supported
    localparam int MAX_MSG_BYTES = 55;  // longest message that still leaves room for 0x80 + length
    localparam int BLOCK_WORDS   = 16;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_PAD     = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;
    localparam logic [2:0] ST_WAIT_LO = 3'd5;
    localparam logic [2:0] ST_DRAIN   = 3'd6;

    // Message length in bytes -> low word of the 64-bit bit-length field (L*8 never exceeds 440).
    function automatic logic [31:0] length_word(input logic [5:0] nbytes);
        return {23'b0, nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_pad_buffer.sv
// 16x32 block buffer: big-endian byte-lane writes, padding/length write, bulk clear and a word read port.
module sha256_pad_buffer
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_we,
    input  logic        pad_we,
    input  logic [5:0]  byte_idx,
    input  logic [7:0]  byte_data,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] mem [BLOCK_WORDS];
    logic [3:0]  word_sel;
    logic [4:0]  lane_lsb;

    // Byte 0 of a word lands in bits [31:24], hence the inverted lane index.
    assign word_sel = byte_idx[5:2];
    assign lane_lsb = {~byte_idx[1:0], 3'b000};

    // NOTE: the buffer is flops, not RAM, and IDLE relies on it being all-zero, so reset clears every word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
        end else if (pad_we) begin
            mem[word_sel][lane_lsb +: 8] <= PAD_BYTE;
            mem[14] <= '0;
            mem[15] <= length_word(byte_idx);
        end else if (byte_we) begin
            mem[word_sel][lane_lsb +: 8] <= byte_data;
        end
    end

    // Read bypasses a pad write in flight so word 0 can be launched in the PAD cycle itself.
    always_comb begin
        rd_data = mem[rd_idx];
        if (pad_we) begin
            if (rd_idx == word_sel) rd_data[lane_lsb +: 8] = PAD_BYTE;
            if (rd_idx == 4'd14)    rd_data = '0;
            if (rd_idx == 4'd15)    rd_data = length_word(byte_idx);
        end
    end

endmodule

// File: rtl/sha256_msg_packer.sv
// Packs a UART byte stream into one padded SHA-256 block and bursts it as 16 words to the core.
module sha256_msg_packer
    import sha256_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv_in,
    input  logic [7:0]            rx_byte_in,
    input  logic                  rx_last_in,
    input  logic                  core_dv_in,
    output logic                  MP_dv_out,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  busy_out,
    output logic                  err_out
);

    logic [2:0]  state, state_nx;
    logic [5:0]  byte_cnt, byte_cnt_nx;
    logic [3:0]  word_cnt, word_cnt_nx;
    logic        buf_clear, byte_we, pad_we, load_word, err_set, err_clr;
    logic [5:0]  byte_idx;
    logic [3:0]  rd_idx;
    logic [31:0] rd_data;

    sha256_pad_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .byte_we   (byte_we),
        .pad_we    (pad_we),
        .byte_idx  (byte_idx),
        .byte_data (rx_byte_in),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        word_cnt_nx = word_cnt;
        buf_clear   = 1'b0;
        byte_we     = 1'b0;
        pad_we      = 1'b0;
        load_word   = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        byte_idx    = byte_cnt;
        rd_idx      = word_cnt;

        case (state)
            ST_IDLE: begin
                if (rx_dv_in) begin
                    byte_we     = 1'b1;
                    byte_idx    = 6'd0;
                    byte_cnt_nx = 6'd1;
                    err_clr     = 1'b1;
                    state_nx    = rx_last_in ? ST_PAD : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_dv_in) begin
                    // A 56th byte cannot fit; the message is abandoned, ending now if it was the last byte.
                    if (byte_cnt == 6'(MAX_MSG_BYTES)) begin
                        err_set = 1'b1;
                        if (rx_last_in) begin
                            buf_clear   = 1'b1;
                            byte_cnt_nx = 6'd0;
                            state_nx    = ST_IDLE;
                        end else begin
                            state_nx = ST_DRAIN;
                        end
                    end else begin
                        byte_we     = 1'b1;
                        byte_cnt_nx = byte_cnt + 6'd1;
                        if (rx_last_in) state_nx = ST_PAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_dv_in && rx_last_in) begin
                    buf_clear   = 1'b1;
                    byte_cnt_nx = 6'd0;
                    state_nx    = ST_IDLE;
                end
            end
            ST_PAD: begin
                pad_we      = 1'b1;
                rd_idx      = 4'd0;
                load_word   = 1'b1;
                word_cnt_nx = 4'd1;
                err_set     = rx_dv_in;
                state_nx    = ST_SEND;
            end
            ST_SEND: begin
                load_word   = 1'b1;
                word_cnt_nx = word_cnt + 4'd1;
                err_set     = rx_dv_in;
                if (word_cnt == 4'd15) state_nx = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                err_set = rx_dv_in;
                if (core_dv_in) state_nx = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                err_set = rx_dv_in;
                if (!core_dv_in) begin
                    buf_clear   = 1'b1;
                    byte_cnt_nx = 6'd0;
                    word_cnt_nx = 4'd0;
                    state_nx    = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            MP_dv_out   <= 1'b0;
            message_out <= '0;
            busy_out    <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            state       <= state_nx;
            byte_cnt    <= byte_cnt_nx;
            word_cnt    <= word_cnt_nx;
            MP_dv_out   <= load_word;
            message_out <= load_word ? rd_data : '0;
            busy_out    <= !(state_nx == ST_IDLE || state_nx == ST_COLLECT);
            if (err_clr)      err_out <= 1'b0;
            else if (err_set) err_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Directed bench for sha256_msg_packer: table of single-block messages plus error/reset sequences.
module tb_sha256_msg_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv_in;
    logic [7:0]  rx_byte_in;
    logic        rx_last_in;
    logic        core_dv_in;
    logic        MP_dv_out;
    logic [31:0] message_out;
    logic        busy_out;
    logic        err_out;

    sha256_msg_packer dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dv_in    (rx_dv_in),
        .rx_byte_in  (rx_byte_in),
        .rx_last_in  (rx_last_in),
        .core_dv_in  (core_dv_in),
        .MP_dv_out   (MP_dv_out),
        .message_out (message_out),
        .busy_out    (busy_out),
        .err_out     (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nbytes;
        logic [7:0]  first;
        int          idx;
        logic [31:0] exp_at_idx;
        logic [31:0] exp_w15;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] got_w [16];
    int          got_lat;
    int          checks = 0;
    int          errors = 0;
    int          dv_cycles = 0;

    always @(negedge clk) if (MP_dv_out) dv_cycles++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected block word k for a message of len bytes valued first, first+1, ...
    function automatic logic [31:0] exp_word(input int len, input logic [7:0] first, input int k);
        logic [31:0] w;
        logic [7:0]  v;
        int          b;
        w = '0;
        if (k == 15) return 32'(len * 8);
        if (k == 14) return '0;
        for (int j = 0; j < 4; j++) begin
            b = 4 * k + j;
            if (b < len)       v = first + 8'(b);
            else if (b == len) v = 8'h80;
            else               v = 8'h00;
            w = {w[23:0], v};
        end
        return w;
    endfunction

    // Bytes go back-to-back; returns at the first negedge after the last byte was sampled.
    task automatic send_msg(input int len, input logic [7:0] first);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_dv_in   = 1'b1;
            rx_byte_in = first + 8'(i);
            rx_last_in = (i == len - 1);
        end
        @(negedge clk);
        rx_dv_in   = 1'b0;
        rx_last_in = 1'b0;
    endtask

    task automatic capture_burst(input int inject_at);
        int waited;
        int dv_run;
        waited = 0;
        dv_run = 0;
        while (!MP_dv_out && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        got_lat = waited;
        check("burst_start", {31'b0, MP_dv_out}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (MP_dv_out) dv_run++;
            got_w[i]   = message_out;
            rx_dv_in   = (i == inject_at);
            rx_byte_in = 8'hEE;
            rx_last_in = (i == inject_at);
        end
        @(negedge clk);
        rx_dv_in   = 1'b0;
        rx_last_in = 1'b0;
        check("dv_run_len", 32'(dv_run), 32'd16);
        check("dv_after_burst", {31'b0, MP_dv_out}, 32'd0);
        check("msg_after_burst", message_out, 32'd0);
        check("busy_wait_core", {31'b0, busy_out}, 32'd1);
    endtask

    task automatic finish_core();
        core_dv_in = 1'b1;
        @(negedge clk);
        check("busy_core_hi", {31'b0, busy_out}, 32'd1);
        core_dv_in = 1'b0;
        @(negedge clk);
        check("busy_core_lo", {31'b0, busy_out}, 32'd0);
    endtask

    task automatic run_msg(input int len, input logic [7:0] first, input int inject_at);
        send_msg(len, first);
        capture_burst(inject_at);
        check("word0_latency", 32'(got_lat), 32'd1);
        for (int k = 0; k < 16; k++)
            check($sformatf("len%0d_w%0d", len, k), got_w[k], exp_word(len, first, k));
        finish_core();
    endtask

    initial begin
        int snap;
        vecs[0] = '{3,  8'h61, 0,  32'h61626380, 32'h00000018};
        vecs[1] = '{1,  8'h00, 0,  32'h00800000, 32'h00000008};
        vecs[2] = '{55, 8'h01, 13, 32'h35363780, 32'h000001B8};
        vecs[3] = '{4,  8'h10, 1,  32'h80000000, 32'h00000020};
        vecs[4] = '{7,  8'hA0, 1,  32'hA4A5A680, 32'h00000038};

        rst        = 1'b1;
        rx_dv_in   = 1'b0;
        rx_byte_in = 8'h00;
        rx_last_in = 1'b0;
        core_dv_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dv", {31'b0, MP_dv_out}, 32'd0);
        check("rst_msg", message_out, 32'd0);
        check("rst_busy", {31'b0, busy_out}, 32'd0);
        check("rst_err", {31'b0, err_out}, 32'd0);

        // rx_last_in alone must not start anything
        rx_last_in = 1'b1;
        @(negedge clk);
        rx_last_in = 1'b0;
        @(negedge clk);
        check("lone_last_busy", {31'b0, busy_out}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            run_msg(vecs[v].nbytes, vecs[v].first, -1);
            check($sformatf("vec%0d_word%0d", v, vecs[v].idx), got_w[vecs[v].idx], vecs[v].exp_at_idx);
            check($sformatf("vec%0d_w15", v), got_w[15], vecs[v].exp_w15);
            check($sformatf("vec%0d_err", v), {31'b0, err_out}, 32'd0);
        end

        // Overlength: 56 bytes, last on the 56th -> error, no burst
        snap = dv_cycles;
        send_msg(56, 8'h01);
        repeat (25) @(negedge clk);
        check("ovl_no_burst", 32'(dv_cycles - snap), 32'd0);
        check("ovl_err", {31'b0, err_out}, 32'd1);
        check("ovl_busy", {31'b0, busy_out}, 32'd0);
        send_msg(1, 8'h61);
        check("ovl_err_cleared", {31'b0, err_out}, 32'd0);
        capture_burst(-1);
        check("a_w0", got_w[0], 32'h61800000);
        check("a_w15", got_w[15], 32'h00000008);
        finish_core();

        // Byte pulsed mid-burst is dropped and flagged
        run_msg(3, 8'h61, 5);
        check("drop_err", {31'b0, err_out}, 32'd1);
        run_msg(2, 8'h78, -1);
        check("drop_next_w0", got_w[0], 32'h78798000);
        check("drop_next_err", {31'b0, err_out}, 32'd0);

        // Reset at SEND word 7
        send_msg(3, 8'h61);
        begin
            int waited;
            waited = 0;
            while (!MP_dv_out && waited < 40) begin
                @(negedge clk);
                waited++;
            end
        end
        check("rstmid_dv_start", {31'b0, MP_dv_out}, 32'd1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_dv", {31'b0, MP_dv_out}, 32'd0);
        check("rstmid_msg", message_out, 32'd0);
        check("rstmid_busy", {31'b0, busy_out}, 32'd0);
        check("rstmid_err", {31'b0, err_out}, 32'd0);
        rst = 1'b0;
        snap = dv_cycles;
        repeat (4) @(negedge clk);
        check("rstmid_no_resume", 32'(dv_cycles - snap), 32'd0);
        run_msg(3, 8'h61, -1);
        check("rstmid_abc_w0", got_w[0], 32'h61626380);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
